// File: rtl/thread_cmd_arbiter_pkg.sv
// Shared encodings for the thread-manager command arbiter: command codes, manager control
// states, default operand widths and the arbiter FSM state type.
package thread_cmd_arbiter_pkg;

    localparam int unsigned DATA_SIZE = 32;
    localparam int unsigned ADDR_SIZE = 32;

    localparam logic [3:0] THREAD_CMD_RUN  = 4'h1;
    localparam logic [3:0] THREAD_CMD_STOP = 4'h2;

    localparam logic [7:0] CTL_CPU_LOOP = 8'h01;
    localparam logic [7:0] CTL_CPU_CMD  = 8'h02;

    typedef enum logic [1:0] {
        ArbIdle  = 2'b00,
        ArbIssue = 2'b01,
        ArbCapt  = 2'b10,
        ArbResp  = 2'b11
    } arb_state_e;

    // Only fork and kill reach the manager; anything else is refused locally.
    function automatic logic is_fwd_cmd(input logic [3:0] cmd);
        return (cmd == THREAD_CMD_RUN) || (cmd == THREAD_CMD_STOP);
    endfunction

endpackage

// File: rtl/thread_cmd_arbiter_rr_pick.sv
// Round-robin picker: first set request searching upward from ptr+1, wrapping at CPU_N.
module thread_cmd_arbiter_rr_pick #(
    parameter int unsigned CPU_N = 4,
    localparam int unsigned IDX_W = (CPU_N > 1) ? $clog2(CPU_N) : 1
) (
    input  logic [CPU_N-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [CPU_N-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int unsigned k;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int unsigned i = 1; i <= CPU_N; i++) begin
            k = 32'(ptr) + i;
            if (k >= CPU_N) begin
                k = k - CPU_N;
            end
            if (!valid && req[k[IDX_W-1:0]]) begin
                valid               = 1'b1;
                grant[k[IDX_W-1:0]] = 1'b1;
                idx                 = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/thread_cmd_arbiter.sv
// Round-robin arbiter sharing the thread-manager command port between CPU_N cores.
// Optional THRD_ARB_STOP_PRIO_EN: kill requests win over fork requests in IDLE.
module thread_cmd_arbiter
    import thread_cmd_arbiter_pkg::*;
#(
    parameter int unsigned CPU_N  = 4,
    parameter int unsigned DATA_W = DATA_SIZE,
    parameter int unsigned ADDR_W = ADDR_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_oe,
    input  logic [CPU_N-1:0]        req,
    input  logic [4*CPU_N-1:0]      req_cmd,
    input  logic [DATA_W*CPU_N-1:0] req_data,
    input  logic [ADDR_W*CPU_N-1:0] req_addr,
    output logic [CPU_N-1:0]    done,
    output logic [1:0]          rsp_rslt,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                busy,
    output logic [7:0]          tm_ctl_state,
    output logic [3:0]          tm_cmd,
    output logic [DATA_W-1:0]   tm_data,
    output logic [ADDR_W-1:0]   tm_addr,
    input  logic [1:0]          tm_rslt,
    input  logic [DATA_W-1:0]   tm_data_in
);

    localparam int unsigned IDX_W = (CPU_N > 1) ? $clog2(CPU_N) : 1;

    arb_state_e       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win_idx;
    logic [CPU_N-1:0] win_grant;

    logic [CPU_N-1:0] pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;

`ifdef THRD_ARB_STOP_PRIO_EN
    logic [CPU_N-1:0] stop_vec;
    logic [CPU_N-1:0] stop_grant, all_grant;
    logic [IDX_W-1:0] stop_idx, all_idx;
    logic             stop_valid, all_valid;

    always_comb begin
        stop_vec = '0;
        for (int unsigned c = 0; c < CPU_N; c++) begin
            stop_vec[c] = req[c] && (req_cmd[4*c +: 4] == THREAD_CMD_STOP);
        end
    end

    thread_cmd_arbiter_rr_pick #(.CPU_N(CPU_N)) u_pick_stop (
        .req   (stop_vec),
        .ptr   (ptr),
        .grant (stop_grant),
        .idx   (stop_idx),
        .valid (stop_valid)
    );

    thread_cmd_arbiter_rr_pick #(.CPU_N(CPU_N)) u_pick_all (
        .req   (req),
        .ptr   (ptr),
        .grant (all_grant),
        .idx   (all_idx),
        .valid (all_valid)
    );

    assign pick_grant = stop_valid ? stop_grant : all_grant;
    assign pick_idx   = stop_valid ? stop_idx   : all_idx;
    assign pick_valid = all_valid;
`else
    thread_cmd_arbiter_rr_pick #(.CPU_N(CPU_N)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );
`endif

    logic [3:0]        sel_cmd;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] sel_addr;

    assign sel_cmd  = req_cmd[32'(pick_idx)*4 +: 4];
    assign sel_data = req_data[32'(pick_idx)*DATA_W +: DATA_W];
    assign sel_addr = req_addr[32'(pick_idx)*ADDR_W +: ADDR_W];

    assign busy = (state != ArbIdle);

    // The tm_* registers double as the latched operands of the granted command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ArbIdle;
            ptr          <= IDX_W'(CPU_N - 1);
            win_idx      <= '0;
            win_grant    <= '0;
            done         <= '0;
            rsp_rslt     <= '0;
            rsp_data     <= '0;
            tm_ctl_state <= CTL_CPU_LOOP;
            tm_cmd       <= '0;
            tm_data      <= '0;
            tm_addr      <= '0;
        end else if (clk_oe) begin
            case (state)
                ArbIdle: begin
                    if (pick_valid) begin
                        win_idx   <= pick_idx;
                        win_grant <= pick_grant;
                        if (is_fwd_cmd(sel_cmd)) begin
                            tm_ctl_state <= CTL_CPU_CMD;
                            tm_cmd       <= sel_cmd;
                            tm_data      <= sel_data;
                            tm_addr      <= sel_addr;
                            state        <= ArbIssue;
                        end else begin
                            rsp_rslt <= '0;
                            rsp_data <= '0;
                            done     <= pick_grant;
                            state    <= ArbResp;
                        end
                    end
                end
                ArbIssue: begin
                    tm_ctl_state <= CTL_CPU_LOOP;
                    tm_cmd       <= '0;
                    tm_data      <= '0;
                    tm_addr      <= '0;
                    state        <= ArbCapt;
                end
                ArbCapt: begin
                    rsp_rslt <= tm_rslt;
                    rsp_data <= tm_data_in;
                    done     <= win_grant;
                    state    <= ArbResp;
                end
                ArbResp: begin
                    done  <= '0;
                    ptr   <= win_idx;
                    state <= ArbIdle;
                end
                default: state <= ArbIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_thread_cmd_arbiter.sv
// Self-checking bench for thread_cmd_arbiter with a behavioural round-robin reference model.
module tb_thread_cmd_arbiter;
    import thread_cmd_arbiter_pkg::*;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clk_oe = 1'b1;
    logic [3:0]    req = '0;
    logic [15:0]   req_cmd = '0;
    logic [127:0]  req_data = '0;
    logic [127:0]  req_addr = '0;
    logic [3:0]    done;
    logic [1:0]    rsp_rslt;
    logic [31:0]   rsp_data;
    logic          busy;
    logic [7:0]    tm_ctl_state;
    logic [3:0]    tm_cmd;
    logic [31:0]   tm_data;
    logic [31:0]   tm_addr;
    logic [1:0]    tm_rslt = '0;
    logic [31:0]   tm_data_in = '0;

    int  tests = 0;
    int  fails = 0;
    int  ptr_m = N - 1;
    bit  last_oe;

    thread_cmd_arbiter #(.CPU_N(4), .DATA_W(32), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_oe       (clk_oe),
        .req          (req),
        .req_cmd      (req_cmd),
        .req_data     (req_data),
        .req_addr     (req_addr),
        .done         (done),
        .rsp_rslt     (rsp_rslt),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .tm_ctl_state (tm_ctl_state),
        .tm_cmd       (tm_cmd),
        .tm_data      (tm_data),
        .tm_addr      (tm_addr),
        .tm_rslt      (tm_rslt),
        .tm_data_in   (tm_data_in)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge; last_oe tells whether the posedge just passed was enabled.
    task automatic step(input bit toggle);
        last_oe = clk_oe;
        @(negedge clk);
        clk_oe = toggle ? ~clk_oe : 1'b1;
    endtask

    task automatic set_req(input int k, input logic [3:0] cmd, input logic [31:0] d,
                           input logic [31:0] a);
        req[k]             = 1'b1;
        req_cmd[4*k +: 4]  = cmd;
        req_data[32*k +: 32] = d;
        req_addr[32*k +: 32] = a;
    endtask

    function automatic logic [3:0] rand_cmd();
        logic [3:0] c;
        case ($urandom % 4)
            0, 1:    c = THREAD_CMD_RUN;
            2:       c = THREAD_CMD_STOP;
            default: c = 4'($urandom);
        endcase
        return c;
    endfunction

    // Reference arbitration: scan ptr+1, ptr+2, ... modulo N; optionally STOP requesters first.
    function automatic int predict(input logic [3:0] r, input logic [15:0] c, input int p);
        int win = -1;
`ifdef THRD_ARB_STOP_PRIO_EN
        for (int i = 1; i <= N; i++) begin
            int k = (p + i) % N;
            if (win < 0 && r[k] && c[4*k +: 4] == THREAD_CMD_STOP) win = k;
        end
`endif
        for (int i = 1; i <= N; i++) begin
            int k = (p + i) % N;
            if (win < 0 && r[k]) win = k;
        end
        return win;
    endfunction

    // Follows one command from the IDLE decision edge through done and back to IDLE.
    task automatic run_txn(input int w, input bit toggle, input bit early_drop,
                           input bit keep_req);
        logic [3:0]  ecmd  = req_cmd[4*w +: 4];
        logic [31:0] edata = req_data[32*w +: 32];
        logic [31:0] eaddr = req_addr[32*w +: 32];
        bit          fwd   = (ecmd == THREAD_CMD_RUN) || (ecmd == THREAD_CMD_STOP);
        logic [1:0]  erslt = fwd ? tm_rslt : 2'd0;
        logic [31:0] erdat = fwd ? tm_data_in : 32'd0;
        int en = 0;
        int cmdc = 0;
        int n;
        bit got = 0;
        for (n = 0; n < 64 && !got; n++) begin
            step(toggle);
            if (last_oe) begin
                en++;
                if (tm_ctl_state == CTL_CPU_CMD) begin
                    cmdc++;
                    chk("tm_cmd", 64'(tm_cmd), 64'(ecmd));
                    chk("tm_data", 64'(tm_data), 64'(edata));
                    chk("tm_addr", 64'(tm_addr), 64'(eaddr));
                end
                if (en == 1 && early_drop) req[w] = 1'b0;
            end
            if (done != 4'b0) got = 1;
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("done_vec", 64'(done), 64'(4'b0001 << w));
        chk("rsp_rslt", 64'(rsp_rslt), 64'(erslt));
        chk("rsp_data", 64'(rsp_data), 64'(erdat));
        chk("latency", 64'(en), fwd ? 64'd3 : 64'd1);
        chk("cmd_cycles", 64'(cmdc), fwd ? 64'd1 : 64'd0);
        chk("busy_resp", 64'(busy), 64'd1);
        if (!keep_req) req[w] = 1'b0;
        n = 0;
        do begin
            step(toggle);
            n++;
        end while (!last_oe && n < 8);
        chk("done_pulse_end", 64'(done), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("rsp_hold", 64'(rsp_data), 64'(erdat));
        ptr_m = w;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_rslt"}, 64'(rsp_rslt), 64'd0);
        chk({tag, "_rdata"}, 64'(rsp_data), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_ctl"}, 64'(tm_ctl_state), 64'(CTL_CPU_LOOP));
        chk({tag, "_cmd"}, 64'(tm_cmd), 64'd0);
        chk({tag, "_data"}, 64'(tm_data), 64'd0);
        chk({tag, "_addr"}, 64'(tm_addr), 64'd0);
    endtask

    initial begin
        int w;
        int seq [5] = '{0, 1, 2, 3, 0};

        // Reset values
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        step(0);

        // Single RUN from core 2
        tm_rslt = 2'd1;
        tm_data_in = 32'hFFFF_FFFF;
        set_req(2, THREAD_CMD_RUN, 32'd5, 32'h40);
        chk("pred_single", 64'(predict(req, req_cmd, ptr_m)), 64'd2);
        run_txn(2, 0, 0, 0);

        // Invalid command on core 1 is refused without reaching the manager
        set_req(1, 4'hF, 32'h1234, 32'h80);
        run_txn(1, 0, 0, 0);

        // Requester drops before done; command still completes
        tm_rslt = 2'd0;
        tm_data_in = 32'd0;
        set_req(3, THREAD_CMD_STOP, 32'h77, 32'hC0);
        run_txn(3, 0, 1, 0);

        // clk_oe toggling every cycle
        tm_rslt = 2'd1;
        tm_data_in = 32'hFFFF_FFFF;
        set_req(0, THREAD_CMD_RUN, 32'hABCD, 32'h100);
        run_txn(0, 1, 0, 0);

        // Reset while issuing abandons the command
        step(0);
        set_req(0, THREAD_CMD_RUN, 32'h9, 32'h10);
        step(0);
        chk("mid_issue_ctl", 64'(tm_ctl_state), 64'(CTL_CPU_CMD));
        #1 rst = 1'b0;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        req = '0;
        rst = 1'b1;
        ptr_m = N - 1;
        for (int i = 0; i < 6; i++) begin
            step(0);
            chk("no_done_after_rst", 64'(done), 64'd0);
        end

        // Fairness: all cores requesting continuously from reset
        for (int k = 0; k < N; k++) set_req(k, THREAD_CMD_RUN, $urandom, $urandom);
        for (int i = 0; i < 5; i++) begin
            chk("fair_model", 64'(predict(req, req_cmd, ptr_m)), 64'(seq[i]));
            run_txn(seq[i], 0, 0, 1);
        end
        req = '0;
        step(0);

        // STOP vs RUN from reset with ptr at CPU_N-1
        rst = 1'b0;
        step(0);
        rst = 1'b1;
        ptr_m = N - 1;
        set_req(0, THREAD_CMD_RUN, 32'h11, 32'h22);
        set_req(3, THREAD_CMD_STOP, 32'h33, 32'h44);
`ifdef THRD_ARB_STOP_PRIO_EN
        run_txn(3, 0, 0, 0);
        run_txn(0, 0, 0, 0);
`else
        run_txn(0, 0, 0, 0);
        run_txn(3, 0, 0, 0);
`endif

        // Randomized traffic against the reference model
        for (int t = 0; t < 25; t++) begin
            if (req == 4'b0) set_req($urandom % N, rand_cmd(), $urandom, $urandom);
            tm_rslt = 2'($urandom % 2);
            tm_data_in = (tm_rslt != 0) ? 32'hFFFF_FFFF : 32'd0;
            w = predict(req, req_cmd, ptr_m);
            run_txn(w, bit'($urandom % 2), ($urandom % 4) == 0, 0);
            for (int k = 0; k < N; k++) begin
                if (!req[k] && ($urandom % 2) == 1) set_req(k, rand_cmd(), $urandom, $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
